spm_shift_register: RTL
=======================

// Module: spm_shift_register
// PURPOSE
//  Parametrised serial-out operand register for the signed serial-parallel multiplier (SPM).
//  Accepts a WIDTH-bit multiplier operand in parallel and emits it LSB-first, one bit per clock.
//  Then emits EXT_CYCLES copies of the operand sign bit, so the SPM array sees a 2N-bit
//  sign-extended serial stream. Sits between the operand source and the SPM adder/flip-flop chain.
// PARAMETERS
//  WIDTH       32     operand width in bits; legal range >= 2
//  EXT_CYCLES  32     sign-extension beats after the data bits; 0 = no extension phase
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous reset, active-low
//  load_valid  in   1      parallel operand offered
//  load_data   in   WIDTH  operand, two's complement
//  load_ready  out  1      operand accepted this cycle when load_valid && load_ready
//  sout        out  1      serial bit, registered
//  sout_valid  out  1      sout carries a live bit this cycle
//  sout_last   out  1      this beat is the final beat of the stream
//  busy        out  1      stream in progress (state != IDLE)
//  stall       in   1      only when SPM_SREG_STALL_EN is defined; freezes the stream
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous):
//      - state=IDLE; shift reg, count, sign, sout, sout_valid, sout_last, busy all 0.
//      - load_ready is a combinational decode and reads 1 in IDLE.
//  - FSM IDLE -> SHIFT -> EXTEND -> IDLE.
//      - EXTEND is skipped when EXT_CYCLES==0.
//      - Stream length L = WIDTH+EXT_CYCLES beats.
//  - Accept (load_valid && load_ready) at edge t:
//      - Capture load_data; sign <= load_data[WIDTH-1]; count <= 0; state <= SHIFT.
//      - First beat: sout=load_data[0], sout_valid=1 in cycle t+1. Latency is 1 clock.
//  - SHIFT: beat k (k=0..WIDTH-1) drives sout=operand[k]; logical right shift each clock.
//  - EXTEND: sout=sign on every beat.
//  - sout_last=1 on beat L-1 only.
//  - Leaving SHIFT/EXTEND after beat L-1 returns to IDLE, or restarts SHIFT on back-to-back accept.
//  - load_ready = (state==IDLE) || (sout_last && !stall_eff).
//      - Back-to-back accept on the last beat gives a gap-free stream; no idle cycle between operands.
//  - load_valid while busy and not on the last beat: ignored; no state change, operand not captured.
//  - count is an unsigned counter, $clog2(L+1) bits, wrapping never allowed (saturates at L-1).
//  - Reset mid-stream: stream aborted immediately; sout_valid falls asynchronously; no partial resume.
//  - sout_valid=0 in IDLE; sout holds 0 in IDLE.
// CONFIGURATION
//  SPM_SREG_STALL_EN defined:
//    - Port stall exists. stall=1 holds state, count, shift data, sout and sout_last unchanged.
//    - sout_valid=0 while stall=1.
//    - A stalled last beat does not assert load_ready.
//    - Stall in IDLE has no effect; loads still accepted.
//  SPM_SREG_STALL_EN undefined: no stall port; stall_eff tied 0; stream never pauses.
// STRUCTURE
//  Package spm_pkg:
//    - typedef enum logic [1:0] {IDLE, SHIFT, EXTEND} spm_sreg_state_t.
//    - function spm_cnt_w(L) returning $clog2(L+1).
//  Sub-module spm_bit_counter:
//    - Parametrised up-counter with clear, enable and terminal-count flag (count==MAX-1).
//    - Shared later by the SPM product-collect stage.
//  Top: FSM, shift register and output registers.
// TESTING
//  T1 reset: assert rst_n=0 mid-stream (beat 5) -> sout_valid, busy, sout drop to 0 with no clock
//     edge; load_ready=1 after release.
//  T2 WIDTH=8, EXT=8:
//     - Load 8'hA5 -> beats 0..7 = 1,0,1,0,0,1,0,1, then 8 beats of 1.
//     - sout_last on beat 15; busy low at cycle 17.
//  T3 WIDTH=8, EXT=8, back-to-back:
//     - Load 8'h03, then 8'h80 on the last beat -> 32 contiguous valid beats, no gap.
//     - Second stream: 0000000 1 then 8 ones.
//  T4 ignore: load_valid with 8'hFF during beat 3 of 8'h01 -> stream unchanged; no capture.
//  T5 EXT_CYCLES=0, WIDTH=4, load 4'h9 -> beats 1,0,0,1; sout_last on beat 3; no EXTEND state.
//  T6 STALL_EN, WIDTH=8, EXT=8:
//     - stall=1 for 3 cycles at beat 4 of 8'h5A -> sout_valid low 3 cycles.
//     - Resumes at beat 4; total 16 valid beats; last beat stalled holds load_ready=0.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared types and helpers for the signed serial-parallel multiplier datapath.
package spm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      EXTEND = 2'd2
   } spm_sreg_state_t;

   // Bits needed to count 0..l inclusive.
   function automatic int spm_cnt_w(input int l);
      return $clog2(l + 1);
   endfunction

endpackage

// File: rtl/spm_bit_counter.sv
// Saturating up-counter with synchronous clear, enable and a terminal-count flag.
// Also reused by the SPM product-collect stage.
module spm_bit_counter #(
   parameter int MAX = 16,
   parameter int W   = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         tc
);

   localparam logic [W-1:0] LAST = W'(MAX - 1);

   logic [W-1:0] count_reg;

   // Holds at MAX-1 instead of wrapping, so tc stays asserted until cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en && (count_reg != LAST)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;
   assign tc    = (count_reg == LAST);

endmodule

// File: rtl/spm_shift_register.sv
// Serial-out operand register: emits a WIDTH-bit operand LSB-first, then EXT_CYCLES sign bits.
// Optional stall port is enabled by defining SPM_SREG_STALL_EN.
module spm_shift_register
   import spm_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int EXT_CYCLES = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic             busy
`ifdef SPM_SREG_STALL_EN
   ,
   input  logic             stall
`endif
);

   localparam int L  = WIDTH + EXT_CYCLES;
   localparam int CW = spm_cnt_w(L);
   localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);

   spm_sreg_state_t  state_reg, state_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic             sign_reg, sign_next;
   logic             sout_reg, sout_next;
   logic [CW-1:0]    count;
   logic             tc;
   logic             stall_eff;
   logic             accept;
   logic             advance;

`ifdef SPM_SREG_STALL_EN
   assign stall_eff = stall;
`else
   assign stall_eff = 1'b0;
`endif

   // count is cleared on every accept, so tc while busy marks beat L-1.
   assign busy       = (state_reg != IDLE);
   assign sout_valid = busy && !stall_eff;
   assign sout_last  = busy && tc;
   assign load_ready = !busy || (sout_last && !stall_eff);
   assign accept     = load_valid && load_ready;
   assign advance    = busy && !stall_eff;
   assign sout       = sout_reg;

   spm_bit_counter #(
      .MAX (L),
      .W   (CW)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (advance),
      .count (count),
      .tc    (tc)
   );

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      sign_next  = sign_reg;
      sout_next  = sout_reg;
      if (accept) begin
         // Bit 0 goes straight to the output register; the rest waits in shift_reg.
         state_next = SHIFT;
         shift_next = {1'b0, load_data[WIDTH-1:1]};
         sout_next  = load_data[0];
         sign_next  = load_data[WIDTH-1];
      end else if (advance) begin
         if (tc) begin
            state_next = IDLE;
            sout_next  = 1'b0;
         end else if (count < DATA_LAST) begin
            sout_next  = shift_reg[0];
            shift_next = {1'b0, shift_reg[WIDTH-1:1]};
         end else begin
            state_next = EXTEND;
            sout_next  = sign_reg;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         sign_reg  <= 1'b0;
         sout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         sign_reg  <= sign_next;
         sout_reg  <= sout_next;
      end
   end

endmodule
